cpu_dfm_responder: RTL and testbench

Data flash memory (DFM) responder that serves the pipeline CPU's memory-stage load/store requests. It holds a word-addressed data array with asynchronous read and synchronous write. After reset, an initialization state machine clears the array and deasserts `dfm_ready` until the clear completes, so the hazard unit can stall. Misaligned or out-of-range accesses are blocked, and the first such fault is captured for diagnosis.

---
 rtl/cpu_dfm_responder.sv | 135 +++++++++++++
 tb/tb_cpu_dfm_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_dfm_responder.sv
// rtl/cpu_dfm_responder.sv - data flash memory responder for the CPU memory stage
module cpu_dfm_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 1024
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  dfm_req_en,
    input  logic [ADDR_WIDTH-1:0] dfm_req_addr,
    input  logic                  dfm_wr_en,
    input  logic [DATA_WIDTH-1:0] dfm_wr_data,
    output logic [DATA_WIDTH-1:0] dfm_rd_data,
    output logic                  dfm_ready,
    input  logic                  dfm_err_clr,
    output logic                  dfm_err,
    output logic [ADDR_WIDTH-1:0] dfm_err_addr,
    output logic                  dfm_err_wr
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MEM_DEPTH - 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [IDX_W-1:0]       init_idx_q;
    logic [IDX_W-1:0]       init_idx_d;

    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];

    logic [IDX_W-1:0]       idx;
    logic                   misaligned;
    logic                   out_of_range;
    logic                   fault;
    logic                   rd_ok;
    logic                   wr_ok;

    logic                   mem_we;
    logic [IDX_W-1:0]       mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdata;

    // Address decode: word index plus alignment and range qualification.
    always_comb begin
        idx          = dfm_req_addr[IDX_W+1:2];
        misaligned   = (dfm_req_addr[1:0] != 2'b00);
        out_of_range = ((dfm_req_addr >> (IDX_W + 2)) != '0);
        fault        = dfm_req_en & dfm_ready & (misaligned | out_of_range);
        rd_ok        = dfm_ready & dfm_req_en & ~dfm_wr_en & ~fault;
        wr_ok        = dfm_ready & dfm_req_en &  dfm_wr_en & ~fault;
    end

    // State register: INIT/READY and the clear pointer.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // Next-state and array write-port selection; INIT owns the write port.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        mem_we     = 1'b0;
        mem_waddr  = idx;
        mem_wdata  = dfm_wr_data;
        case (state_q)
            ST_INIT: begin
                mem_we     = 1'b1;
                mem_waddr  = init_idx_q;
                mem_wdata  = '0;
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == LAST_IDX) begin
                    state_d    = ST_READY;
                    init_idx_d = '0;
                end
            end
            ST_READY: begin
                mem_we = wr_ok;
            end
            default: begin
                state_d    = ST_INIT;
                init_idx_d = '0;
            end
        endcase
    end

    // Ready flag, registered so the hazard unit sees a clean level.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dfm_ready <= 1'b0;
        end else begin
            dfm_ready <= (state_d == ST_READY);
        end
    end

    // Data array: synchronous write, writes during reset are discarded.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Asynchronous read, zero unless this is a clean load in READY.
    always_comb begin
        dfm_rd_data = '0;
        if (rd_ok) begin
            dfm_rd_data = mem[idx];
        end
    end

    // Sticky fault capture; a new fault outranks a clear in the same cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            dfm_err      <= 1'b0;
            dfm_err_addr <= '0;
            dfm_err_wr   <= 1'b0;
        end else if (fault && (!dfm_err || dfm_err_clr)) begin
            dfm_err      <= 1'b1;
            dfm_err_addr <= dfm_req_addr;
            dfm_err_wr   <= dfm_wr_en;
        end else if (dfm_err_clr) begin
            dfm_err      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cpu_dfm_responder.sv
// tb/tb_cpu_dfm_responder.sv - randomized self-checking bench for cpu_dfm_responder
module tb_cpu_dfm_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          sys_clk = 1'b0;
    logic          sys_rst;
    logic          dfm_req_en;
    logic [AW-1:0] dfm_req_addr;
    logic          dfm_wr_en;
    logic [DW-1:0] dfm_wr_data;
    logic [DW-1:0] dfm_rd_data;
    logic          dfm_ready;
    logic          dfm_err_clr;
    logic          dfm_err;
    logic [AW-1:0] dfm_err_addr;
    logic          dfm_err_wr;

    cpu_dfm_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .dfm_req_en   (dfm_req_en),
        .dfm_req_addr (dfm_req_addr),
        .dfm_wr_en    (dfm_wr_en),
        .dfm_wr_data  (dfm_wr_data),
        .dfm_rd_data  (dfm_rd_data),
        .dfm_ready    (dfm_ready),
        .dfm_err_clr  (dfm_err_clr),
        .dfm_err      (dfm_err),
        .dfm_err_addr (dfm_err_addr),
        .dfm_err_wr   (dfm_err_wr)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    int            ref_edges;      // non-reset edges since last reset
    logic          ref_err;
    logic [AW-1:0] ref_err_addr;
    logic          ref_err_wr;
    logic [DW-1:0] last_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_ready();
        return ref_edges >= DEPTH;
    endfunction

    function automatic bit ref_fault(input logic en, input logic [AW-1:0] a);
        return en && ref_ready() && ((a % 4) != 0 || a >= 4 * DEPTH);
    endfunction

    task automatic step(input logic rst, input logic en, input logic [AW-1:0] a,
                        input logic wr, input logic [DW-1:0] wd, input logic clr,
                        input string tag);
        logic [DW-1:0] exp_rd;
        bit f;
        sys_rst      = rst;
        dfm_req_en   = en;
        dfm_req_addr = a;
        dfm_wr_en    = wr;
        dfm_wr_data  = wd;
        dfm_err_clr  = clr;
        #1;
        f      = ref_fault(en, a);
        exp_rd = (ref_ready() && en && !wr && !f) ? ref_mem[a / 4] : '0;
        last_rd = dfm_rd_data;
        if (!rst) chk({tag, "_rd"}, dfm_rd_data, exp_rd);
        @(posedge sys_clk);
        if (rst) begin
            ref_edges    = 0;
            ref_err      = 0;
            ref_err_addr = '0;
            ref_err_wr   = 0;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (!ref_ready()) begin
            ref_edges++;
        end else begin
            if (f && (!ref_err || clr)) begin
                ref_err      = 1;
                ref_err_addr = a;
                ref_err_wr   = wr;
            end else if (clr) begin
                ref_err = 0;
            end
            if (en && wr && !f) ref_mem[a / 4] = wd;
        end
        #1;
        chk({tag, "_ready"},   dfm_ready,    ref_ready());
        chk({tag, "_err"},     dfm_err,      ref_err);
        chk({tag, "_erraddr"}, dfm_err_addr, ref_err_addr);
        chk({tag, "_errwr"},   dfm_err_wr,   ref_err_wr);
    endtask

    task automatic idle(input string tag);
        step(0, 0, '0, 0, '0, 0, tag);
    endtask

    initial begin
        logic [AW-1:0] ra;
        int sel;
        ref_edges = 0;
        ref_err = 0;
        ref_err_addr = '0;
        ref_err_wr = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        step(1, 0, '0, 0, '0, 0, "rst");
        step(1, 0, '0, 0, '0, 0, "rst");
        chk("rst_ready", dfm_ready, 1'b0);
        chk("rst_err", dfm_err, 1'b0);

        // initialization window: loads and stores ignored, reads return 0
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 1, 32'h10, (i % 2) == 1, 32'hFFFF_FFFF, 0, "init");
            if (i % 2 == 0) chk("init_rd_zero", last_rd, 32'h0);
            if (i < DEPTH - 1) chk("init_not_ready", dfm_ready, 1'b0);
        end
        chk("init_ready", dfm_ready, 1'b1);

        // store then load
        step(0, 1, 32'h10, 1, 32'hDEAD_BEEF, 0, "st10");
        step(0, 1, 32'h10, 0, '0, 0, "ld10");
        chk("ld10_val", last_rd, 32'hDEAD_BEEF);
        step(0, 1, 32'h14, 0, '0, 0, "ld14");
        chk("ld14_val", last_rd, 32'h0);

        // misaligned store, then later fault keeps first capture
        step(0, 1, 32'h12, 1, 32'h1234_5678, 0, "st12");
        chk("st12_err", dfm_err, 1'b1);
        chk("st12_addr", dfm_err_addr, 32'h12);
        step(0, 1, 32'h40, 0, '0, 0, "ld40");
        chk("ld40_addr", dfm_err_addr, 32'h12);
        step(0, 1, 32'h10, 0, '0, 0, "ld10b");
        chk("ld10b_val", last_rd, 32'hDEAD_BEEF);

        // clear coincident with fault: fault wins
        step(0, 1, 32'h100, 0, '0, 1, "clrflt");
        chk("clrflt_addr", dfm_err_addr, 32'h100);
        chk("clrflt_wr", dfm_err_wr, 1'b0);
        step(0, 0, '0, 0, '0, 1, "clr");
        chk("clr_err", dfm_err, 1'b0);
        chk("clr_hold", dfm_err_addr, 32'h100);

        // load before store shows old data; store then load shows new
        step(0, 1, 32'h4, 1, 32'h1111_2222, 0, "st4a");
        step(0, 1, 32'h4, 0, '0, 0, "ld4a");
        step(0, 1, 32'h4, 1, 32'h3333_4444, 0, "st4b");
        step(0, 1, 32'h4, 0, '0, 0, "ld4b");
        chk("ld4b_val", last_rd, 32'h3333_4444);

        // reset mid-operation re-clears the array
        step(0, 1, 32'h8, 1, 32'hA5A5_A5A5, 0, "st8");
        step(1, 1, 32'hC, 1, 32'h5A5A_5A5A, 0, "rstmid");
        chk("rstmid_ready", dfm_ready, 1'b0);
        for (int i = 0; i < DEPTH; i++) idle("reinit");
        step(0, 1, 32'h8, 0, '0, 0, "ld8");
        chk("ld8_val", last_rd, 32'h0);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            sel = $urandom_range(0, 99);
            if (sel < 70)      ra = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (sel < 85) ra = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
            else               ra = $urandom | 32'h0000_1000;
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), ra,
                 $urandom_range(0, 1) == 1, $urandom, ($urandom_range(0, 9) == 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
